alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one signed add/subtract datapath between `NREQ` requesters, such as the fetch PC incrementer, the execute stage and the address generator. Each granted request is computed in one pass through the internal add/sub core. The block registers the result with its Z/N/V status and returns it on a single valid/ready response channel tagged with the requester index. It sits between the pipeline stages and the shared ALU adder, so the design carries one adder instead of one per stage.

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu_addsub_core.sv | 30 +++
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the alu_arbiter slice: status bit positions, FSM states, size defaults.
package alu_arb_pkg;

    localparam int STAT_Z = 2;
    localparam int STAT_N = 1;
    localparam int STAT_V = 0;

    localparam int WIDTH_DEF = 16;
    localparam int NREQ_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FULL   = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_addsub_core.sv
// Combinational signed add/subtract with {Z, N, V} status generation.
module alu_addsub_core
    import alu_arb_pkg::*;
#(
    parameter int width = WIDTH_DEF
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             sub,
    output logic [width-1:0] value,
    output logic [2:0]       status
);

    logic [width-1:0] b_x_s;
    logic [width:0]   sum_s;
    logic [width-1:0] low_s;

    // Subtraction is A + ~B + 1; the lower-bit sum exposes the carry into the MSB for V.
    always_comb begin
        b_x_s  = b ^ {width{sub}};
        sum_s  = {1'b0, a} + {1'b0, b_x_s} + {{width{1'b0}}, sub};
        low_s  = {1'b0, a[width-2:0]} + {1'b0, b_x_s[width-2:0]} + {{(width-1){1'b0}}, sub};
        value  = sum_s[width-1:0];
        status = 3'b000;
        status[STAT_Z] = (sum_s[width-1:0] == {width{1'b0}});
        status[STAT_N] = sum_s[width-1];
        status[STAT_V] = low_s[width-1] ^ sum_s[width];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one add/sub core between NREQ requesters, single-slot response.
// Optional grant locking for multi-word sequences is built when ALU_ARB_LOCK_EN is defined.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int width = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*width-1:0]     req_Ain,
    input  logic [NREQ*width-1:0]     req_Bin,
    input  logic [NREQ-1:0]           req_sub,
    input  logic [NREQ-1:0]           req_lock,
    output logic [NREQ-1:0]           grant,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [width-1:0]          rsp_value,
    output logic [2:0]                rsp_status
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] ID_ONE  = IDW'(1);

    arb_state_e        state_r, state_next_s;
    logic [IDW-1:0]    ptr_r;
    logic              rsp_valid_r, valid_next_s;
    logic [IDW-1:0]    rsp_id_r;
    logic [width-1:0]  rsp_value_r;
    logic [2:0]        rsp_status_r;

    logic              slot_free_s, xfer_s, lock_take_s;
    logic [NREQ-1:0]   elig_s, grant_s;
    logic [IDW-1:0]    xfer_id_s;
    logic [width-1:0]  a_s, b_s, value_s;
    logic              sub_s;
    logic [2:0]        status_s;

`ifdef ALU_ARB_LOCK_EN
    logic [IDW-1:0]    owner_r;

    // A held lock narrows the field to its owner; otherwise every valid requester competes.
    always_comb begin
        if (state_r == LOCKED) begin
            elig_s = req_valid & ({{(NREQ-1){1'b0}}, 1'b1} << owner_r);
        end else begin
            elig_s = req_valid;
        end
        lock_take_s = req_lock[xfer_id_s];
    end
`else
    logic lock_unused_s;

    // Without locking, every valid requester competes and req_lock has no effect.
    always_comb begin
        elig_s        = req_valid;
        lock_take_s   = 1'b0;
        lock_unused_s = ^req_lock;
    end
`endif

    // Round-robin search from ptr; nothing is granted while the slot is occupied or in reset.
    always_comb begin
        logic found_v;
        logic hit_v;
        int   idx_v;
        slot_free_s = ~rsp_valid_r | rsp_ready;
        grant_s     = {NREQ{1'b0}};
        xfer_id_s   = {IDW{1'b0}};
        found_v     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx_v          = (int'(ptr_r) + i) % NREQ;
            hit_v          = slot_free_s & ~reset & ~found_v & elig_s[idx_v];
            grant_s[idx_v] = hit_v;
            xfer_id_s      = hit_v ? IDW'(idx_v) : xfer_id_s;
            found_v        = found_v | hit_v;
        end
        xfer_s = found_v;
    end

    // Operand mux feeding the single shared core.
    always_comb begin
        a_s   = req_Ain[xfer_id_s*width +: width];
        b_s   = req_Bin[xfer_id_s*width +: width];
        sub_s = req_sub[xfer_id_s];
    end

    alu_addsub_core #(.width(width)) u_core (
        .a      (a_s),
        .b      (b_s),
        .sub    (sub_s),
        .value  (value_s),
        .status (status_s)
    );

    // Next-state logic; a pop and a new transfer in the same cycle keep the slot full.
    always_comb begin
        state_next_s = state_r;
        valid_next_s = xfer_s | (rsp_valid_r & ~rsp_ready);
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_next_s = lock_take_s ? LOCKED : FULL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FULL: begin
                if (xfer_s) begin
                    state_next_s = lock_take_s ? LOCKED : FULL;
                end else if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FULL;
                end
            end
`ifdef ALU_ARB_LOCK_EN
            LOCKED: begin
                if (xfer_s && !lock_take_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = LOCKED;
                end
            end
`endif
            default: state_next_s = IDLE;
        endcase
    end

    // State, pointer and output slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            ptr_r        <= {IDW{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {IDW{1'b0}};
            rsp_value_r  <= {width{1'b0}};
            rsp_status_r <= 3'b000;
`ifdef ALU_ARB_LOCK_EN
            owner_r      <= {IDW{1'b0}};
`endif
        end else begin
            state_r     <= state_next_s;
            rsp_valid_r <= valid_next_s;
            if (xfer_s) begin
                ptr_r        <= (xfer_id_s == ID_LAST) ? {IDW{1'b0}} : xfer_id_s + ID_ONE;
                rsp_id_r     <= xfer_id_s;
                rsp_value_r  <= value_s;
                rsp_status_r <= status_s;
`ifdef ALU_ARB_LOCK_EN
                owner_r      <= xfer_id_s;
`endif
            end else begin
                ptr_r        <= ptr_r;
                rsp_id_r     <= rsp_id_r;
                rsp_value_r  <= rsp_value_r;
                rsp_status_r <= rsp_status_r;
            end
        end
    end

    assign grant      = grant_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_value  = rsp_value_r;
    assign rsp_status = rsp_status_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (width=8, NREQ=4): directed plan plus randomized traffic vs. a behavioural model.
module tb_alu_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_sub, req_lock, grant;
    logic [N*W-1:0] req_Ain, req_Bin;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_value;
    logic [2:0]     rsp_status;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model: pointer, one pending response, lock owner.
    int m_ptr    = 0;
    bit m_valid  = 1'b0;
    int m_id     = 0;
    int m_val    = 0;
    int m_stat   = 0;
    bit m_fresh  = 1'b1;
    bit m_locked = 1'b0;
    int m_owner  = 0;

    alu_arbiter #(.width(W), .NREQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_Ain    (req_Ain),
        .req_Bin    (req_Bin),
        .req_sub    (req_sub),
        .req_lock   (req_lock),
        .grant      (grant),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_value  (rsp_value),
        .rsp_status (rsp_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Signed arithmetic on integers; status = {Z,N,V}.
    task automatic alu_ref(input int a, input int b, input bit sub, output int val, output int stat);
        int sa, sb, r;
        sa   = (a >= 128) ? a - 256 : a;
        sb   = (b >= 128) ? b - 256 : b;
        r    = sub ? sa - sb : sa + sb;
        val  = r & 255;
        stat = ((val == 0) ? 4 : 0) | ((val >= 128) ? 2 : 0) | ((r > 127 || r < -128) ? 1 : 0);
    endtask

    function automatic int exp_grant_idx();
        if (reset || (m_valid && !rsp_ready)) return -1;
        for (int off = 0; off < N; off++) begin
            int k = (m_ptr + off) % N;
            if (req_valid[k] && (!m_locked || k == m_owner)) return k;
        end
        return -1;
    endfunction

    // One cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input int lit_grant);
        int g, v, s;
        @(negedge clk);
        g = exp_grant_idx();
        chk("grant", 32'(grant), (g < 0) ? 0 : (1 << g));
        if (lit_grant >= 0) chk("grant_lit", 32'(grant), lit_grant);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid || m_fresh) begin
            chk("rsp_id", 32'(rsp_id), m_id);
            chk("rsp_value", 32'(rsp_value), m_val);
            chk("rsp_status", 32'(rsp_status), m_stat);
        end
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_valid = 0; m_id = 0; m_val = 0; m_stat = 0;
            m_fresh = 1; m_locked = 0; m_owner = 0;
        end else if (g >= 0) begin
            alu_ref(int'(req_Ain[g*W +: W]), int'(req_Bin[g*W +: W]), req_sub[g], v, s);
            m_valid = 1; m_id = g; m_val = v; m_stat = s; m_fresh = 0;
            m_ptr = (g + 1) % N;
`ifdef ALU_ARB_LOCK_EN
            m_locked = req_lock[g];
            m_owner  = g;
`endif
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic clr_req();
        req_valid = '0; req_Ain = '0; req_Bin = '0; req_sub = '0; req_lock = '0;
    endtask

    task automatic set_req(input int k, input int a, input int b, input bit sub, input bit lk);
        req_valid[k]     = 1'b1;
        req_Ain[k*W +: W] = W'(a);
        req_Bin[k*W +: W] = W'(b);
        req_sub[k]       = sub;
        req_lock[k]      = lk;
    endtask

    initial begin
        logic [W-1:0] held_val;
        logic [2:0]   held_stat;
        reset = 1'b1; rsp_ready = 1'b1; clr_req();
        step(0);
        step(0);
        reset = 1'b0;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_value", 32'(rsp_value), 0);
        chk("rst_status", 32'(rsp_status), 0);

        // Signed overflow on add, overflow on subtract, zero result.
        set_req(0, 'h7F, 'h01, 1'b0, 1'b0);
        step(1);
        clr_req();
        chk("t1_id", 32'(rsp_id), 0);
        chk("t1_value", 32'(rsp_value), 'h80);
        chk("t1_status", 32'(rsp_status), 3'b011);
        set_req(2, 'h80, 'h01, 1'b1, 1'b0);
        step(4);
        chk("t2_value", 32'(rsp_value), 'h7F);
        chk("t2_status", 32'(rsp_status), 3'b001);
        set_req(2, 'h05, 'h05, 1'b1, 1'b0);
        step(4);
        chk("t3_value", 32'(rsp_value), 'h00);
        chk("t3_status", 32'(rsp_status), 3'b100);
        clr_req();

        // All four requesting back to back after reset.
        reset = 1'b1; step(0); reset = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 16 * k + 1, k, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1 << (i % N));
            chk("rr_id", 32'(rsp_id), i % N);
        end
        clr_req();

        // Backpressure: slot full, consumer stalled for three cycles.
        rsp_ready = 1'b0;
        set_req(1, 'h33, 'h11, 1'b1, 1'b0);
        held_val  = rsp_value;
        held_stat = rsp_status;
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("stall_value", 32'(rsp_value), 32'(held_val));
            chk("stall_status", 32'(rsp_status), 32'(held_stat));
        end
        rsp_ready = 1'b1;
        step(2);
        chk("unstall_id", 32'(rsp_id), 1);
        chk("unstall_value", 32'(rsp_value), 'h22);
        clr_req();

        // Reset with a response pending.
        for (int k = 0; k < N; k++) set_req(k, k + 3, 1, 1'b1, 1'b0);
        rsp_ready = 1'b0;
        reset = 1'b1;
        step(0);
        reset = 1'b0; rsp_ready = 1'b1;
        chk("rstp_valid", 32'(rsp_valid), 0);
        step(1);
        clr_req();

`ifdef ALU_ARB_LOCK_EN
        // Locked sequence from requester 3 while 0 and 1 also request.
        reset = 1'b1; step(0); reset = 1'b0;
        set_req(2, 1, 1, 1'b0, 1'b0);
        step(4);
        clr_req();
        set_req(0, 10, 1, 1'b0, 1'b0);
        set_req(1, 20, 1, 1'b0, 1'b0);
        set_req(3, 'hFF, 'h01, 1'b0, 1'b1);
        step(8);
        step(8);
        req_lock[3] = 1'b0;
        step(8);
        step(1);
        clr_req();
`endif

        // Randomized traffic with occasional reset and backpressure.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(99) == 0);
            rsp_ready = ($urandom_range(3) != 0);
            req_valid = N'($urandom);
            req_Ain   = (N*W)'($urandom);
            req_Bin   = (N*W)'($urandom);
            req_sub   = N'($urandom);
            req_lock  = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            step(-1);
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
